// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game referee.
package reaction_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RACE,
    RESULT,
    MATCH_OVER
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int WIN_SCORE_DFLT = 5;
endpackage

// File: rtl/reaction_referee_if.sv
// Player/countdown inputs and score/result outputs of the referee.
interface reaction_referee_if #(parameter int SCORE_W = 4);
  logic               start;
  logic               go;
  logic               sw_p1;
  logic               sw_p2;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         round_winner;
  logic [1:0]         false_start;
  logic               match_over;

  modport master (
    output start, go, sw_p1, sw_p2,
    input  p1_score, p2_score, round_winner, false_start, match_over
  );
  modport slave (
    input  start, go, sw_p1, sw_p2,
    output p1_score, p2_score, round_winner, false_start, match_over
  );
endinterface

// File: rtl/reaction_referee_sync_edge.sv
// Multi-flop synchronizer with a registered level and registered rising-edge pulse.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic cin,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;

  // level and pulse share one register stage so both arrive on the same edge
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    level_d = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~level_q;
  end

  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
endmodule

// File: rtl/reaction_referee.sv
// Round referee: decides win / tie / false start and keeps saturating scores.
module reaction_referee
  import reaction_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = WIN_SCORE_DFLT,
  parameter int SYNC_STAGES = 2
) (
  input logic              cin,
  input logic              reset,
  reaction_referee_if.slave bus
);
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE     = SCORE_W'(1);

  logic start_p, p1_p, p2_p, go_l;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .cin(cin), .reset(reset), .d(bus.start), .level(), .pulse(start_p));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sw_p1 (
    .cin(cin), .reset(reset), .d(bus.sw_p1), .level(), .pulse(p1_p));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sw_p2 (
    .cin(cin), .reset(reset), .d(bus.sw_p2), .level(), .pulse(p2_p));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_go (
    .cin(cin), .reset(reset), .d(bus.go), .level(go_l), .pulse());

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         fs_q, fs_d;
  logic               armed_seen_q, armed_seen_d;

  always_comb begin
    state_d      = state_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    winner_d     = winner_q;
    fs_d         = fs_q;
    armed_seen_d = armed_seen_q;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d      = ARMED;
          winner_d     = WIN_NONE;
          fs_d         = 2'b00;
          armed_seen_d = 1'b0;
        end
      end
      ARMED: begin
        // a jump beats a simultaneous go rise
        if (p1_p || p2_p) begin
          fs_d = {p2_p, p1_p};
          if (p1_p && p1_q != '0) p1_d = p1_q - ONE;
          if (p2_p && p2_q != '0) p2_d = p2_q - ONE;
          state_d = RESULT;
        end else if (go_l && armed_seen_q) begin
          state_d = RACE;
        end else if (!go_l) begin
          armed_seen_d = 1'b1;
        end
      end
      RACE: begin
        if (p1_p && p2_p) begin
          winner_d = WIN_TIE;
          state_d  = RESULT;
        end else if (p1_p) begin
          if (p1_q != WIN_VAL) p1_d = p1_q + ONE;
          winner_d = WIN_P1;
          state_d  = RESULT;
        end else if (p2_p) begin
          if (p2_q != WIN_VAL) p2_d = p2_q + ONE;
          winner_d = WIN_P2;
          state_d  = RESULT;
        end
      end
      RESULT: begin
        if (p1_q == WIN_VAL || p2_q == WIN_VAL) begin
          state_d = MATCH_OVER;
        end else if (start_p) begin
          state_d      = ARMED;
          winner_d     = WIN_NONE;
          fs_d         = 2'b00;
          armed_seen_d = 1'b0;
        end
      end
      MATCH_OVER: begin
        if (start_p) begin
          state_d      = ARMED;
          p1_d         = '0;
          p2_d         = '0;
          winner_d     = WIN_NONE;
          fs_d         = 2'b00;
          armed_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cin or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      winner_q     <= WIN_NONE;
      fs_q         <= 2'b00;
      armed_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      fs_q         <= fs_d;
      armed_seen_q <= armed_seen_d;
    end
  end

  assign bus.p1_score     = p1_q;
  assign bus.p2_score     = p2_q;
  assign bus.round_winner = winner_q;
  assign bus.false_start  = fs_q;
  assign bus.match_over   = (state_q == MATCH_OVER);
endmodule

// File: tb/tb_reaction_referee.sv
// Directed scoreboard bench for reaction_referee.
module tb_reaction_referee;
  localparam int SW   = 4;
  localparam int WINS = 5;

  logic cin   = 1'b0;
  logic reset = 1'b1;

  reaction_referee_if #(.SCORE_W(SW)) bus ();

  reaction_referee #(.SCORE_W(SW), .WIN_SCORE(WINS), .SYNC_STAGES(2)) dut (
    .cin(cin), .reset(reset), .bus(bus.slave));

  always #5 cin = ~cin;

  typedef struct {
    int         p1;
    int         p2;
    logic [1:0] w;
    logic [1:0] fs;
    logic       mo;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_p1 = 0, m_p2 = 0;
  logic [1:0] m_w = 2'b00, m_fs = 2'b00;

  task automatic tick(input int n);
    repeat (n) @(posedge cin);
    @(negedge cin);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push();
    exp_t e;
    e.p1 = m_p1; e.p2 = m_p2; e.w = m_w; e.fs = m_fs;
    e.mo = (m_p1 == WINS) || (m_p2 == WINS);
    q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".p1"}, int'(bus.p1_score), e.p1);
      chk({tag, ".p2"}, int'(bus.p2_score), e.p2);
      chk({tag, ".win"}, int'(bus.round_winner), int'(e.w));
      chk({tag, ".fs"}, int'(bus.false_start), int'(e.fs));
      chk({tag, ".mo"}, int'(bus.match_over), int'(e.mo));
    end
  endtask

  task automatic m_win(input logic a, input logic b);
    m_fs = 2'b00;
    if (a && b) m_w = 2'b11;
    else if (a) begin m_w = 2'b01; if (m_p1 < WINS) m_p1++; end
    else if (b) begin m_w = 2'b10; if (m_p2 < WINS) m_p2++; end
    push();
  endtask

  task automatic m_fsr(input logic a, input logic b);
    m_w  = 2'b00;
    m_fs = {b, a};
    if (a && m_p1 > 0) m_p1--;
    if (b && m_p2 > 0) m_p2--;
    push();
  endtask

  task automatic press_start();
    bus.start = 1'b1; tick(1);
    bus.start = 1'b0; tick(3);
  endtask

  task automatic race(input logic a, input logic b, input string tag);
    bus.go = 1'b0;
    press_start();
    bus.go = 1'b1; tick(4);
    bus.sw_p1 = a; bus.sw_p2 = b;
    m_win(a, b);
    tick(5);
    check_out(tag);
    bus.sw_p1 = 1'b0; bus.sw_p2 = 1'b0; tick(3);
  endtask

  task automatic jump(input logic a, input logic b, input string tag);
    bus.go = 1'b0;
    press_start();
    bus.sw_p1 = a; bus.sw_p2 = b;
    m_fsr(a, b);
    tick(5);
    check_out(tag);
    bus.sw_p1 = 1'b0; bus.sw_p2 = 1'b0; tick(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.go = 1'b0; bus.sw_p1 = 1'b0; bus.sw_p2 = 1'b0;
    tick(2);
    push();
    check_out("reset");
    reset = 1'b0;
    tick(2);

    // first round with exact latency: score must not move until edge n+3
    press_start();
    bus.go = 1'b1; tick(4);
    bus.sw_p1 = 1'b1;
    m_win(1'b1, 1'b0);
    tick(3);
    chk("latency_early", int'(bus.p1_score), 0);
    tick(1);
    check_out("p1_win_latency");
    bus.sw_p1 = 1'b0; tick(3);

    race(1'b0, 1'b1, "p2_win_a");
    race(1'b0, 1'b1, "p2_win_b");
    jump(1'b0, 1'b1, "p2_false_2to1");
    jump(1'b0, 1'b1, "p2_false_1to0");
    jump(1'b0, 1'b1, "p2_false_sat0");
    race(1'b1, 1'b1, "tie");
    jump(1'b1, 1'b1, "both_false");

    // stale go: ARMED must wait for go low before racing, so this edge is a jump
    race(1'b1, 1'b0, "p1_win_pre_stale");
    bus.go = 1'b1;
    press_start();
    tick(6);
    bus.sw_p1 = 1'b1;
    m_fsr(1'b1, 1'b0);
    tick(5);
    check_out("stale_go");
    bus.sw_p1 = 1'b0; tick(3);

    for (int i = 0; i < WINS; i++) race(1'b1, 1'b0, "p1_to_match");

    bus.sw_p2 = 1'b1;
    push();
    tick(5);
    check_out("match_over_frozen");
    bus.sw_p2 = 1'b0; tick(3);

    press_start();
    m_p1 = 0; m_p2 = 0; m_w = 2'b00; m_fs = 2'b00;
    push();
    check_out("match_clear");

    bus.go = 1'b0; tick(4);
    bus.go = 1'b1; tick(4);
    bus.sw_p2 = 1'b1;
    m_win(1'b0, 1'b1);
    tick(5);
    check_out("armed_after_clear");
    bus.sw_p2 = 1'b0; tick(3);

    // async reset in the middle of a race
    bus.go = 1'b0;
    press_start();
    bus.go = 1'b1; tick(4);
    @(posedge cin);
    #2 reset = 1'b1;
    #1;
    m_p1 = 0; m_p2 = 0; m_w = 2'b00; m_fs = 2'b00;
    push();
    check_out("async_reset");
    bus.sw_p1 = 1'b1;
    @(negedge cin);
    reset = 1'b0;
    tick(6);
    push();
    check_out("held_sw_idle");
    bus.go = 1'b0;
    press_start();
    bus.go = 1'b1; tick(8);
    push();
    check_out("held_sw_race");
    bus.sw_p1 = 1'b0; tick(3);
    bus.sw_p1 = 1'b1;
    m_win(1'b1, 1'b0);
    tick(5);
    check_out("fresh_edge_scores");
    bus.sw_p1 = 1'b0; tick(3);

    if (q.size() != 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_leftover: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reaction_referee.md
Name: reaction_referee

Overview:
- Round referee and score keeper for the two-player reaction game.
- Sits directly downstream of the countdown counter. It consumes the counter's `lock` ("go") level, the start button and the two player switches.
- Decides each round: win, tie or false start. Maintains saturating player scores and flags match end.
- The scores feed the seven-segment display stage.

Parameters:
- SCORE_W, 4, width of each score output.
- WIN_SCORE, 5, score value that ends the match; must be < 2**SCORE_W.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer; minimum 2.

Ports:
- cin  in  1  system clock (50 MHz board clock).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  raw start request (active-high, already inverted from the push button); rising edge used.
- go  in  1  countdown-finished level from the counter (its lock output).
- sw_p1  in  1  raw player-1 switch (SW0).
- sw_p2  in  1  raw player-2 switch (SW9).
- p1_score  out  SCORE_W  player-1 score.
- p2_score  out  SCORE_W  player-2 score.
- round_winner  out  2  result of the last round: 00 none, 01 p1, 10 p2, 11 tie.
- false_start  out  2  bit0 = p1 jumped early, bit1 = p2 jumped early; valid in RESULT.
- match_over  out  1  high while in MATCH_OVER.

Behaviour:
- Reset: state IDLE; scores 0; round_winner 00; false_start 00; match_over 0; all synchronizer flops 0.
- Input conditioning:
  - start, sw_p1, sw_p2 and go each pass through SYNC_STAGES flops.
  - start, sw_p1 and sw_p2 get a registered rising-edge detect.
  - A switch held high never generates a second event; only 0->1 counts.
- Latency: a raw input level sampled at edge n is acted on at edge n+SYNC_STAGES+1; the resulting outputs are visible after that edge.
- IDLE:
  - start edge -> ARMED.
  - Entering ARMED clears round_winner, false_start and the armed_seen flag.
- ARMED (waiting for countdown):
  - armed_seen sets on the first cycle synced go == 0. A stale go == 1 left over from the previous round is ignored until armed_seen is set.
  - go == 1 with armed_seen set -> RACE.
  - Switch edge while not racing -> false start:
    - that player's false_start bit sets;
    - that player's score decrements, saturating at 0;
    - next state is RESULT.
  - Both edges in the same cycle: both penalised.
  - A false-start edge and a go rise in the same cycle: the false start wins.
- RACE:
  - First switch edge wins: that player's score increments (saturating at WIN_SCORE); round_winner = 01/10; -> RESULT.
  - Both edges in the same cycle: round_winner = 11, no score change, -> RESULT.
  - A switch already high at RACE entry does not score.
  - go falling back to 0 during RACE is ignored.
- RESULT:
  - Outputs held.
  - If either score == WIN_SCORE -> MATCH_OVER on the next edge.
  - Otherwise a start edge -> ARMED.
- MATCH_OVER:
  - match_over = 1; scores frozen; switch edges ignored.
  - start edge clears scores, round_winner and false_start -> ARMED.
- Start edges arriving in ARMED or RACE are ignored; a round cannot be aborted except by reset.
- Reset asserted mid-round forces the reset values immediately (asynchronous), independent of cin.

Decomposition:
- Shared package reaction_pkg holds:
  - the state enum: IDLE, ARMED, RACE, RESULT, MATCH_OVER;
  - winner code constants: WIN_NONE, WIN_P1, WIN_P2, WIN_TIE;
  - default WIN_SCORE.
- One natural sub-module: sync_edge (SYNC_STAGES synchronizer plus registered rising-edge pulse, with a level output). Instantiated for start, sw_p1 and sw_p2.
- go uses the level output of sync_edge only.

Test Plan:
- Reset, start pulse, go 0 then 1, sw_p1 0->1 -> p1_score 1, round_winner 01, false_start 00, latency SYNC_STAGES+1 cycles from sampling edge.
- Start, go held 0, sw_p2 0->1 with p2_score 2 -> false_start 10, p2_score 1; repeat with p2_score 0 -> stays 0.
- In RACE, sw_p1 and sw_p2 rise in the same cin cycle -> round_winner 11, scores unchanged.
- Go already 1 when start arrives, sw_p1 rises before go drops -> no win awarded; sw_p1 edge must not score until go seen 0 then 1.
- p1_score 4, p1 wins -> p1_score 5, match_over 1; further switch edges no effect; start edge -> scores 0, match_over 0, state ARMED.
- Assert reset while in RACE between cin edges -> all outputs return to reset values without a clock edge; sw_p1 held high after release does not score.
